// File: rtl/fb_pkg.sv
// Shared definitions for the frame-delay RAM port arbiter: default geometry,
// FSM state encoding and a saturating counter helper.
package fb_pkg;

    localparam int          FB_ADDR_W     = 19;
    localparam int          FB_DATA_W     = 24;
    localparam int          FB_IMG_TOTAL  = 800 * 600;
    localparam logic [15:0] FB_STARVE_LIM = 16'd4096;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        FILL    = 2'd1,
        LIVE    = 2'd2
    } fb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/fb_stream_addr_gen.sv
// Stream-side address generator: vsync edge detect, effective write address,
// wrap at the end of a frame and last-pixel flag.
module fb_stream_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int IMG_TOTAL = FB_IMG_TOTAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync_i,
    input  logic              accept_i,
    output logic              vs_rise_o,
    output logic [ADDR_W-1:0] eff_addr_o,
    output logic              last_pix_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              vsync_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign vs_rise_o = vsync_i & ~vsync_q;
    assign addr_o    = addr_q;

    // A vsync edge restarts the frame even for a pixel arriving in that same cycle.
    always_comb begin
        eff_addr_o = vs_rise_o ? {ADDR_W{1'b0}} : addr_q;
        last_pix_o = (eff_addr_o == ADDR_W'(IMG_TOTAL - 1));
    end

    // Next stream address: advance on accepted pixel, wrap after the last one.
    always_comb begin
        addr_d = addr_q;
        if (accept_i) begin
            addr_d = last_pix_o ? {ADDR_W{1'b0}} : (eff_addr_o + ADDR_W'(1));
        end else if (vs_rise_o) begin
            addr_d = {ADDR_W{1'b0}};
        end else begin
            addr_d = addr_q;
        end
    end

    // Edge-detect and address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            vsync_q <= vsync_i;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Owns the single-port read-first frame-delay RAM: pixel stream has absolute
// priority, host accesses fill idle cycles; also tracks fill and short frames.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int          ADDR_W     = FB_ADDR_W,
    parameter int          DATA_W     = FB_DATA_W,
    parameter int          IMG_TOTAL  = FB_IMG_TOTAL,
    parameter logic [15:0] STARVE_LIM = FB_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_24bit,
    output logic [DATA_W-1:0] stream_old,
    output logic              stream_old_valid,
    output logic              frame_ready,
    output logic              frame_short,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_starve,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    fb_state_e         state_q;
    logic              frame_ready_q;
    logic              frame_short_q;
    logic              stream_old_valid_q;
    logic              host_gnt_q;
    logic              host_rvalid_q;
    logic              host_starve_q;
    logic              host_starve_d;
    logic [DATA_W-1:0] stream_old_hold_q;
    logic [DATA_W-1:0] host_rdata_hold_q;
    logic [15:0]       wait_q;
    logic [15:0]       wait_d;

    logic              vs_rise_s;
    logic              last_pix_s;
    logic              accept_s;
    logic              gnt_s;
    logic [ADDR_W-1:0] eff_addr_s;
    logic [ADDR_W-1:0] addr_s;

    fb_stream_addr_gen #(
        .ADDR_W    (ADDR_W),
        .IMG_TOTAL (IMG_TOTAL)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync_i    (per_frame_vsync),
        .accept_i   (accept_s),
        .vs_rise_o  (vs_rise_s),
        .eff_addr_o (eff_addr_s),
        .last_pix_o (last_pix_s),
        .addr_o     (addr_s)
    );

    // The WAIT_VS -> FILL edge itself already accepts a pixel at address 0.
    assign accept_s = rst_n & per_frame_clken & ((state_q != WAIT_VS) | vs_rise_s);
    assign gnt_s    = rst_n & host_req & ~host_gnt_q & ~per_frame_clken;

    assign host_gnt         = gnt_s;
    assign stream_old_valid = stream_old_valid_q;
    assign host_rvalid      = host_rvalid_q;
    assign frame_ready      = frame_ready_q;
    assign frame_short      = frame_short_q;
    assign host_starve      = host_starve_q;

    // RAM data is only live for the cycle after the access; hold it otherwise.
    assign stream_old = stream_old_valid_q ? ram_dout : stream_old_hold_q;
    assign host_rdata = host_rvalid_q      ? ram_dout : host_rdata_hold_q;

    // RAM port mux: stream first, host only in a pixel-free cycle.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {ADDR_W{1'b0}};
        ram_din  = {DATA_W{1'b0}};
        if (accept_s) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = eff_addr_s;
            ram_din  = per_img_24bit;
        end else if (gnt_s) begin
            ram_en   = 1'b1;
            ram_we   = host_we;
            ram_addr = host_addr;
            ram_din  = host_wdata;
        end else begin
            ram_en   = 1'b0;
            ram_we   = 1'b0;
        end
    end

    // Host wait counter and sticky starvation flag.
    always_comb begin
        wait_d = wait_q;
        if (gnt_s) begin
            wait_d = 16'd0;
        end else if (host_req) begin
            wait_d = sat_inc16(wait_q);
        end else begin
            wait_d = wait_q;
        end
        host_starve_d = host_starve_q | (wait_d > STARVE_LIM);
    end

    // Frame bookkeeping FSM with registered ready/short flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_VS;
            frame_ready_q <= 1'b0;
            frame_short_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_VS: begin
                    if (vs_rise_s) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (accept_s && last_pix_s) begin
                        state_q       <= LIVE;
                        frame_ready_q <= 1'b1;
                    end else if (vs_rise_s) begin
                        frame_short_q <= 1'b1;
                    end
                end
                LIVE: begin
                    if (vs_rise_s && (addr_s != {ADDR_W{1'b0}})) begin
                        frame_short_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_VS;
                end
            endcase
        end
    end

    // Return-path valids, data holds and arbitration state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stream_old_valid_q <= 1'b0;
            host_gnt_q         <= 1'b0;
            host_rvalid_q      <= 1'b0;
            host_starve_q      <= 1'b0;
            stream_old_hold_q  <= {DATA_W{1'b0}};
            host_rdata_hold_q  <= {DATA_W{1'b0}};
            wait_q             <= 16'd0;
        end else begin
            stream_old_valid_q <= accept_s;
            host_gnt_q         <= gnt_s;
            host_rvalid_q      <= gnt_s & ~host_we;
            host_starve_q      <= host_starve_d;
            wait_q             <= wait_d;
            if (stream_old_valid_q) begin
                stream_old_hold_q <= ram_dout;
            end
            if (host_rvalid_q) begin
                host_rdata_hold_q <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a 16-pixel frame and a behavioural
// read-first RAM; expected values are hand-derived per step.
module tb_fb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_clken;
    logic [23:0] per_img_24bit;
    logic [23:0] stream_old;
    logic        stream_old_valid;
    logic        frame_ready;
    logic        frame_short;
    logic        host_req;
    logic        host_we;
    logic [18:0] host_addr;
    logic [23:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [23:0] host_rdata;
    logic        host_starve;
    logic        ram_en;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [23:0] ram_din;
    logic [23:0] ram_dout = 24'h0;
    logic [23:0] mem [0:31] = '{default: 24'h0};

    int errors = 0;
    int checks = 0;

    fb_port_arbiter #(
        .ADDR_W     (19),
        .DATA_W     (24),
        .IMG_TOTAL  (16),
        .STARVE_LIM (16'd20)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_clken  (per_frame_clken),
        .per_img_24bit    (per_img_24bit),
        .stream_old       (stream_old),
        .stream_old_valid (stream_old_valid),
        .frame_ready      (frame_ready),
        .frame_short      (frame_short),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_gnt         (host_gnt),
        .host_rvalid      (host_rvalid),
        .host_rdata       (host_rdata),
        .host_starve      (host_starve),
        .ram_en           (ram_en),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr[4:0]];
            if (ram_we) begin
                mem[ram_addr[4:0]] <= ram_din;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [23:0] v, input logic [18:0] exp_addr,
                       input logic do_old, input logic [23:0] exp_old);
        per_frame_clken = 1'b1;
        per_img_24bit   = v;
        #1;
        chk("pix_addr", 32'(ram_addr), 32'(exp_addr));
        chk("pix_we", 32'(ram_we), 32'd1);
        step();
        chk("old_valid", 32'(stream_old_valid), 32'd1);
        if (do_old) chk("stream_old", 32'(stream_old), 32'(exp_old));
    endtask

    initial begin
        rst_n = 1'b0; per_frame_vsync = 1'b0; per_frame_clken = 1'b0;
        per_img_24bit = 24'h0; host_req = 1'b0; host_we = 1'b0;
        host_addr = 19'h0; host_wdata = 24'h0;
        step(); step();
        chk("rst_old_valid", 32'(stream_old_valid), 32'd0);
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_short", 32'(frame_short), 32'd0);
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_starve", 32'(host_starve), 32'd0);
        chk("rst_old", 32'(stream_old), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        rst_n = 1'b1;

        // First frame fills an all-zero RAM.
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(24'(i + 1), 19'(i), 1'b1, 24'h0);
            if (i == 14) chk("ready_pre", 32'(frame_ready), 32'd0);
        end
        chk("ready_rise", 32'(frame_ready), 32'd1);
        per_frame_clken = 1'b0;

        // Second frame returns the first frame.
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(24'(24'h100001 + i), 19'(i), 1'b1, 24'(i + 1));
        end
        per_frame_clken = 1'b0;
        chk("mem5", 32'(mem[5]), 32'h100006);
        chk("short_f2", 32'(frame_short), 32'd0);

        // Host read held off by 10 pixels, then granted in first idle cycle.
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'd3;
        for (int i = 0; i < 10; i++) begin
            per_frame_clken = 1'b1;
            #1;
            chk("gnt_blocked", 32'(host_gnt), 32'd0);
            pix(24'(24'h100001 + i), 19'(i), 1'b1, 24'(24'h100001 + i));
        end
        per_frame_clken = 1'b0;
        #1;
        chk("gnt_idle", 32'(host_gnt), 32'd1);
        chk("gnt_addr", 32'(ram_addr), 32'd3);
        chk("gnt_rd_we", 32'(ram_we), 32'd0);
        step();
        chk("rvalid_t3", 32'(host_rvalid), 32'd1);
        chk("rdata_t3", 32'(host_rdata), 32'h100004);
        chk("no_b2b_gnt", 32'(host_gnt), 32'd0);
        host_req = 1'b0;
        for (int i = 10; i < 16; i++) begin
            pix(24'(24'h100001 + i), 19'(i), 1'b1, 24'(24'h100001 + i));
        end
        per_frame_clken = 1'b0;

        // Blanking: host write then read of address 7.
        host_req = 1'b1; host_we = 1'b1; host_addr = 19'd7; host_wdata = 24'hABCDEF;
        #1;
        chk("wr_gnt", 32'(host_gnt), 32'd1);
        chk("wr_we", 32'(ram_we), 32'd1);
        step();
        chk("wr_no_rvalid", 32'(host_rvalid), 32'd0);
        host_we = 1'b0;
        #1;
        chk("rd_gnt_gap", 32'(host_gnt), 32'd0);
        step();
        chk("rd_gnt", 32'(host_gnt), 32'd1);
        step();
        chk("rvalid_t4", 32'(host_rvalid), 32'd1);
        chk("rdata_t4", 32'(host_rdata), 32'hABCDEF);
        host_req = 1'b0;
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(24'(24'h200001 + i), 19'(i), 1'b1,
                (i == 7) ? 24'hABCDEF : 24'(24'h100001 + i));
        end
        per_frame_clken = 1'b0;
        chk("short_f4", 32'(frame_short), 32'd0);

        // Short frame during fill.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("ready_after_rst", 32'(frame_ready), 32'd0);
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix(24'(24'h300001 + i), 19'(i), 1'b1, 24'(24'h200001 + i));
        end
        per_frame_clken = 1'b0;
        chk("short_pre", 32'(frame_short), 32'd0);
        per_frame_vsync = 1'b1; step(); per_frame_vsync = 1'b0;
        chk("short_set", 32'(frame_short), 32'd1);
        chk("ready_short", 32'(frame_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pix(24'(24'h310001 + i), 19'(i), 1'b1,
                (i < 9) ? 24'(24'h300001 + i) : 24'(24'h200001 + i));
            if (i == 14) chk("ready_refill_pre", 32'(frame_ready), 32'd0);
        end
        chk("ready_refill", 32'(frame_ready), 32'd1);
        per_frame_clken = 1'b0;

        // Starvation: 25 blocked cycles against STARVE_LIM=20, wrap across frames.
        host_req = 1'b1; host_we = 1'b0; host_addr = 19'd0;
        for (int i = 0; i < 25; i++) begin
            pix(24'(24'h400001 + i), 19'(i % 16), 1'b0, 24'h0);
            if (i == 19) chk("starve_20", 32'(host_starve), 32'd0);
            if (i == 20) chk("starve_21", 32'(host_starve), 32'd1);
        end
        per_frame_clken = 1'b0;
        #1;
        chk("starve_gnt", 32'(host_gnt), 32'd1);
        step();
        chk("starve_rvalid", 32'(host_rvalid), 32'd1);
        chk("starve_rdata", 32'(host_rdata), 32'h400011);
        chk("starve_sticky", 32'(host_starve), 32'd1);
        host_addr = 19'd1;
        step();
        chk("pre_rst_gnt", 32'(host_gnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("gnt_in_rst", 32'(host_gnt), 32'd0);
        step();
        chk("rst_rvalid2", 32'(host_rvalid), 32'd0);
        chk("rst_starve2", 32'(host_starve), 32'd0);
        chk("rst_ready2", 32'(frame_ready), 32'd0);
        chk("rst_short2", 32'(frame_short), 32'd0);
        chk("rst_oldv2", 32'(stream_old_valid), 32'd0);
        chk("rst_rdata2", 32'(host_rdata), 32'd0);
        chk("rst_old2", 32'(stream_old), 32'd0);
        host_req = 1'b0; rst_n = 1'b1;
        step();
        chk("post_rst_rvalid", 32'(host_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
